// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core: sequences memory, IR, register
// file, ALU and PC updates per instruction, stalling on mem_ready.
module mips_multicycle_ctrl #(
  parameter bit RESET_PC_WRITE = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_INIT = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    JUMP   = 4'd10,
    ADDIEX = 4'd11,
    ADDIWB = 4'd12
  } state_e;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  state_e state_q, state_d;

  // The zero flag gates pc_write_cond in the datapath, not here.
  logic unusedZero;
  assign unusedZero = zero;

  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_INIT;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;
    unique case (state_q)
      S_INIT: begin
        pc_write = RESET_PC_WRITE;
        state_d  = FETCH;
      end
      // A stalled fetch must neither load IR nor advance the PC.
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default: begin
            illegal_op = 1'b1;
            state_d    = FETCH;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) state_d = FETCH;
      end
      EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = FETCH;
      end
      ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = ADDIWB;
      end
      ADDIWB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench for mips_multicycle_ctrl: an instruction-level
// model predicts every cycle's control word, a monitor compares it to the DUT.
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  mips_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcW, pcWC, iOrD, memRd, memWr, irW, memToReg, regDst, regW, srcA;
    logic [1:0] srcB, aluOp, pcSrc;
    logic       illegal;
    logic [3:0] st;
  } ctrl_t;

  ctrl_t      sb[$];
  int         checks = 0;
  int         passes = 0;
  int         cycle = 0;
  int         cur = 0;
  int         plan[$];
  logic [5:0] instrOp = 6'd0;
  int         curIdx = -1;
  int         stallCnt = 0;
  int         rstHold = 2;
  logic [5:0] dirOps[9] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08, 6'h3f, 6'h2b, 6'h2b};

  function automatic bit isLegal(logic [5:0] op);
    return op inside {6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08};
  endfunction

  function automatic logic [5:0] pickOp();
    logic [5:0] op;
    logic [5:0] legal[6] = '{6'h23, 6'h2b, 6'h00, 6'h04, 6'h02, 6'h08};
    if ($urandom_range(0, 4) != 0) return legal[$urandom_range(0, 5)];
    do op = 6'($urandom_range(0, 63)); while (isLegal(op));
    return op;
  endfunction

  // Expected control word for a phase, straight from the per-state output table.
  function automatic ctrl_t refOut(int ph, logic mr, logic [5:0] op);
    ctrl_t r;
    r = '0;
    r.st = 4'(ph);
    case (ph)
      1:  begin r.memRd = 1'b1; r.srcB = 2'b01; r.irW = mr; r.pcW = mr; end
      2:  begin r.srcB = 2'b11; r.illegal = !isLegal(op); end
      3:  begin r.srcA = 1'b1; r.srcB = 2'b10; end
      4:  begin r.memRd = 1'b1; r.iOrD = 1'b1; end
      5:  begin r.regW = 1'b1; r.memToReg = 1'b1; end
      6:  begin r.memWr = 1'b1; r.iOrD = 1'b1; end
      7:  begin r.srcA = 1'b1; r.aluOp = 2'b10; end
      8:  begin r.regW = 1'b1; r.regDst = 1'b1; end
      9:  begin r.srcA = 1'b1; r.aluOp = 2'b01; r.pcWC = 1'b1; r.pcSrc = 2'b01; end
      10: begin r.pcW = 1'b1; r.pcSrc = 2'b10; end
      11: begin r.srcA = 1'b1; r.srcB = 2'b10; end
      12: r.regW = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  task automatic startInstr();
    curIdx++;
    instrOp = (curIdx < 9) ? dirOps[curIdx] : pickOp();
  endtask

  // Phases an instruction walks through after DECODE.
  task automatic buildPlan();
    plan.delete();
    case (instrOp)
      6'h23:   plan = '{3, 4, 5};
      6'h2b:   plan = '{3, 6};
      6'h00:   plan = '{7, 8};
      6'h04:   plan = '{9};
      6'h02:   plan = '{10};
      6'h08:   plan = '{11, 12};
      default: ;
    endcase
  endtask

  task automatic applyStimulus();
    bit mr;
    bit rstNow;
    mr = (curIdx < 9) ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (curIdx == 7 && cur == 6 && stallCnt < 3) mr = 1'b0;
    if (curIdx == 8 && cur == 6) begin
      mr = 1'b0;
      if (stallCnt == 2) rstHold = 2;
    end
    if (curIdx >= 9 && $urandom_range(0, 99) == 0) rstHold = 1 + $urandom_range(0, 1);
    rstNow = (rstHold > 0);
    if (rstNow) rstHold--;
    rst_n     = !rstNow;
    mem_ready = mr;
    zero      = 1'($urandom);
    opcode    = (cur == 2 || cur == 3) ? instrOp : 6'($urandom);
    #1;
    sb.push_back(rstNow ? refOut(0, mr, opcode) : refOut(cur, mr, opcode));
    if (rstNow) begin
      cur = 0;
      plan.delete();
      stallCnt = 0;
    end else begin
      if (cur == 6 && !mr) stallCnt++;
      else stallCnt = 0;
      if ((cur == 1 || cur == 4 || cur == 6) && !mr) begin
      end else if (cur == 0) begin
        cur = 1;
        startInstr();
      end else if (cur == 1) begin
        buildPlan();
        cur = 2;
      end else if (plan.size() > 0) begin
        cur = plan.pop_front();
      end else begin
        cur = 1;
        startInstr();
      end
    end
  endtask

  task automatic checkOutput();
    ctrl_t exp, act;
    exp = sb.pop_front();
    act = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, state_dbg};
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL ctrl cycle %0d: got %h (state %0d) expected %h (state %0d)",
                  cycle, act, act.st, exp, exp.st);
    checks++;
    if (!(mem_read && mem_write)) passes++;
    else $display("[TB] FAIL memExclusive cycle %0d: got rd=%b wr=%b required not both 1",
                  cycle, mem_read, mem_write);
    checks++;
    if (!(reg_write && (pc_write || pc_write_cond))) passes++;
    else $display("[TB] FAIL regPcExclusive cycle %0d: got regW=%b pcW=%b pcWC=%b",
                  cycle, reg_write, pc_write, pc_write_cond);
  endtask

  // Monitor: pops one expectation per presented cycle, independent of stimulus.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) checkOutput();
    end
  end

  initial begin
    $display("[TB] start");
    repeat (3000) begin
      @(negedge clk);
      applyStimulus();
      cycle++;
    end
    @(negedge clk);
    #3;
    checks++;
    if (sb.size() == 0) passes++;
    else $display("[TB] FAIL scoreboardDrain: got %0d pending required 0", sb.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
